serial_burst_slave: RTL and testbench

SERIAL_BURST_SLAVE -- requirements
Module: serial_burst_slave

---
 rtl/serial_burst_slave_if.sv | 22 ++
 rtl/serial_burst_slave.sv | 167 ++++++++++++++++
 tb/tb_serial_burst_slave.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_burst_slave_if.sv
// Bit-serial bus between a burst master and serial_burst_slave.
// All signals are single-bit; one bit moves per clock.
interface serial_burst_slave_if;
  logic control;
  logic wD;
  logic valid;
  logic last;
  logic rD;
  logic rValid;
  logic ready;
  logic err;

  modport master (
    output control, wD, valid, last,
    input  rD, rValid, ready, err
  );

  modport slave (
    input  control, wD, valid, last,
    output rD, rValid, ready, err
  );
endinterface

// File: rtl/serial_burst_slave.sv
// Serial-framed RAM slave: a bit-serial config frame selects a read or
// write of one word, or a wrapping burst, in a DATA_WIDTH x ADDR_DEPTH RAM.
module serial_burst_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_DEPTH = 2000,
  parameter int SLAVES     = 3,
  parameter int ID_WIDTH   = $clog2(SLAVES + 1),
  parameter int SLAVE_ID   = 1
) (
  input logic clk,
  input logic rstN,
  serial_burst_slave_if.slave bus
);
  localparam int AW   = $clog2(ADDR_DEPTH);
  localparam int AW1  = AW + 1;
  localparam int F    = 3 + ID_WIDTH + 2 + AW;
  localparam int CMAX = (F > DATA_WIDTH) ? F : DATA_WIDTH;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [AW:0]         DEPTH  = AW1'(ADDR_DEPTH);
  localparam logic [AW-1:0]       LAST_A = AW'(ADDR_DEPTH - 1);
  localparam logic [ID_WIDTH-1:0] MY_ID  = ID_WIDTH'(SLAVE_ID);

  typedef enum logic [2:0] {
    IDLE, CONFIG, DECODE, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT
  } state_t;

  state_t                state;
  state_t                nxt;
  logic [F-1:0]          frame;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] sreg;
  logic [AW-1:0]         addr;
  logic                  burst;
  logic                  last_seen;
  logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];

  logic [2:0]          f_start;
  logic [ID_WIDTH-1:0] f_id;
  logic                f_rw;
  logic                f_burst;
  logic [AW-1:0]       f_addr;
  logic                id_ok;
  logic                range_ok;
  logic                cnt_f_end;
  logic                cnt_w_end;
  logic                rd_more;
  logic                wr_more;
  logic [AW-1:0]       addr_inc;

  assign f_start   = frame[F-1 -: 3];
  assign f_id      = frame[F-4 -: ID_WIDTH];
  assign f_rw      = frame[AW+1];
  assign f_burst   = frame[AW];
  assign f_addr    = frame[AW-1:0];
  assign id_ok     = (f_start == 3'b111) && (f_id == MY_ID);
  assign range_ok  = {1'b0, f_addr} < DEPTH;
  assign cnt_f_end = cnt == CW'(F - 1);
  assign cnt_w_end = cnt == CW'(DATA_WIDTH - 1);
  // last on the final read bit counts as seen during that word
  assign rd_more   = burst && !(last_seen || bus.last);
  assign wr_more   = burst && !last_seen;
  assign addr_inc  = (addr == LAST_A) ? '0 : addr + AW'(1);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt        = state;
    bus.ready  = 1'b0;
    bus.err    = 1'b0;
    bus.rValid = 1'b0;
    bus.rD     = 1'b0;
    unique case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.control) nxt = CONFIG;
      end
      CONFIG: begin
        bus.ready = 1'b1;
        if (cnt_f_end) nxt = DECODE;
      end
      DECODE: begin
        if (!id_ok) begin
          nxt = IDLE;
        end else if (!range_ok) begin
          bus.err = 1'b1;
          nxt     = IDLE;
        end else begin
          nxt = f_rw ? WR_SHIFT : RD_LOAD;
        end
      end
      RD_LOAD: nxt = RD_SHIFT;
      RD_SHIFT: begin
        bus.rValid = 1'b1;
        bus.rD     = sreg[DATA_WIDTH-1];
        if (cnt_w_end) nxt = rd_more ? RD_LOAD : IDLE;
      end
      WR_SHIFT: begin
        bus.ready = 1'b1;
        if (bus.valid && cnt_w_end) nxt = WR_COMMIT;
      end
      WR_COMMIT: nxt = wr_more ? WR_SHIFT : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      frame     <= '0;
      cnt       <= '0;
      sreg      <= '0;
      addr      <= '0;
      burst     <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          frame <= {frame[F-2:0], bus.control};
          cnt   <= CW'(1);
        end
        CONFIG: begin
          frame <= {frame[F-2:0], bus.control};
          cnt   <= cnt + CW'(1);
        end
        DECODE: begin
          cnt       <= '0;
          last_seen <= 1'b0;
          if (id_ok && range_ok) begin
            addr  <= f_addr;
            burst <= f_burst;
          end
        end
        RD_LOAD: begin
          sreg      <= mem[addr];
          cnt       <= '0;
          last_seen <= 1'b0;
        end
        RD_SHIFT: begin
          sreg      <= {sreg[DATA_WIDTH-2:0], 1'b0};
          cnt       <= cnt + CW'(1);
          last_seen <= last_seen | bus.last;
          if (cnt_w_end && rd_more) addr <= addr_inc;
        end
        WR_SHIFT: begin
          if (bus.valid) begin
            sreg <= {sreg[DATA_WIDTH-2:0], bus.wD};
            cnt  <= cnt + CW'(1);
            if (cnt_w_end) last_seen <= bus.last;
          end
        end
        WR_COMMIT: begin
          cnt <= '0;
          if (wr_more) addr <= addr_inc;
        end
        default: ;
      endcase
    end
  end

  // RAM has no reset so its contents survive rstN
  always_ff @(posedge clk) begin
    if (state == WR_COMMIT) mem[addr] <= sreg;
  end
endmodule

// File: tb/tb_serial_burst_slave.sv
// Directed bench for serial_burst_slave: table of single transfers plus
// hand-written burst, stall and mid-write reset sequences.
module tb_serial_burst_slave;
  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   checks = 0;
  int   errors = 0;

  serial_burst_slave_if bus();

  serial_burst_slave #(
    .DATA_WIDTH(8),
    .ADDR_DEPTH(12),
    .SLAVES(3),
    .ID_WIDTH(2),
    .SLAVE_ID(1)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw;
    logic [1:0] id;
    logic [3:0] addr;
    logic [7:0] data;
    logic       exp_err;
    logic       act;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [1:0] id, input logic rw,
                            input logic burst, input logic [3:0] addr);
    logic [10:0] f;
    f = {3'b111, id, rw, burst, addr};
    for (int i = 10; i >= 0; i--) begin
      bus.control = f[i];
      tick();
    end
    bus.control = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input logic lst,
                           input int stall_at, input int stall_len);
    for (int i = 7; i >= 0; i--) begin
      if (i == stall_at) begin
        bus.valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk("stall_ready", bus.ready, 1);
        end
      end
      bus.valid = 1'b1;
      bus.wD    = d[i];
      bus.last  = lst && (i == 0);
      tick();
    end
    bus.valid = 1'b0;
    bus.wD    = 1'b0;
    bus.last  = 1'b0;
  endtask

  task automatic recv_word(output logic [7:0] d, input logic lst);
    int   w;
    logic run_ok;
    w      = 0;
    run_ok = 1'b1;
    d      = '0;
    while (!bus.rValid && w < 4) begin
      tick();
      w++;
    end
    if (!bus.rValid) begin
      chk("rvalid_timeout", bus.rValid, 1);
      return;
    end
    for (int i = 7; i >= 0; i--) begin
      run_ok   = run_ok & bus.rValid & ~bus.err;
      d[i]     = bus.rD;
      bus.last = lst && (i == 0);
      tick();
    end
    bus.last = 1'b0;
    chk("rvalid_run", run_ok, 1);
  endtask

  task automatic single_read(input logic [3:0] a, output logic [7:0] d);
    send_frame(2'd1, 1'b0, 1'b0, a);
    recv_word(d, 1'b0);
  endtask

  initial begin
    vec_t       v;
    logic [7:0] got;

    bus.control = 1'b0;
    bus.wD      = 1'b0;
    bus.valid   = 1'b0;
    bus.last    = 1'b0;

    vecs[0]  = '{1'b1, 2'd1, 4'd3,  8'hA5, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 2'd1, 4'd3,  8'hA5, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 2'd1, 4'd0,  8'h3C, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 2'd2, 4'd3,  8'hFF, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 2'd1, 4'd3,  8'hA5, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 2'd1, 4'd13, 8'h77, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 4'd0,  8'h3C, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 2'd1, 4'd11, 8'h81, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 2'd1, 4'd11, 8'h81, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 2'd2, 4'd0,  8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 2'd1, 4'd12, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 2'd0, 4'd3,  8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 2'd1, 4'd3,  8'hA5, 1'b0, 1'b1};

    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", bus.ready, 1);
    chk("rst_rvalid", bus.rValid, 0);
    chk("rst_rd", bus.rD, 0);
    chk("rst_err", bus.err, 0);
    rstN = 1'b1;
    tick();

    for (int k = 0; k < 13; k++) begin
      v = vecs[k];
      send_frame(v.id, v.rw, 1'b0, v.addr);
      chk($sformatf("v%0d_err", k), bus.err, v.exp_err);
      chk($sformatf("v%0d_dec_ready", k), bus.ready, 0);
      if (!v.act) begin
        tick();
        chk($sformatf("v%0d_idle_ready", k), bus.ready, 1);
        chk($sformatf("v%0d_err_drop", k), bus.err, 0);
        chk($sformatf("v%0d_no_rvalid", k), bus.rValid, 0);
      end else if (v.rw) begin
        tick();
        send_word(v.data, 1'b1, -1, 0);
        chk($sformatf("v%0d_commit", k), bus.ready, 0);
        tick();
        chk($sformatf("v%0d_wr_idle", k), bus.ready, 1);
      end else begin
        tick();
        chk($sformatf("v%0d_lat1", k), bus.rValid, 0);
        tick();
        chk($sformatf("v%0d_lat2", k), bus.rValid, 1);
        recv_word(got, 1'b1);
        chk($sformatf("v%0d_data", k), got, v.data);
        chk($sformatf("v%0d_rd_end", k), bus.rValid, 0);
      end
    end

    // burst write 10, 11, then wrap to 0
    send_frame(2'd1, 1'b1, 1'b1, 4'd10);
    tick();
    send_word(8'h11, 1'b0, -1, 0);
    chk("bw_commit0", bus.ready, 0);
    tick();
    send_word(8'h22, 1'b0, -1, 0);
    tick();
    send_word(8'h33, 1'b1, -1, 0);
    chk("bw_commit2", bus.ready, 0);
    tick();
    chk("bw_idle", bus.ready, 1);

    send_frame(2'd1, 1'b0, 1'b1, 4'd10);
    recv_word(got, 1'b0);
    chk("br_w10", got, 8'h11);
    recv_word(got, 1'b0);
    chk("br_w11", got, 8'h22);
    recv_word(got, 1'b1);
    chk("br_w0", got, 8'h33);
    chk("br_end_rvalid", bus.rValid, 0);
    tick();
    tick();
    chk("br_idle_rvalid", bus.rValid, 0);
    chk("br_idle_ready", bus.ready, 1);

    single_read(4'd11, got);
    chk("wrap_single_11", got, 8'h22);

    // valid held low for 5 cycles in the middle of a word
    send_frame(2'd1, 1'b1, 1'b0, 4'd5);
    tick();
    send_word(8'h5A, 1'b0, 4, 5);
    tick();
    single_read(4'd5, got);
    chk("stall_data", got, 8'h5A);

    // reset asserted while the 4th data bit is on the wire
    send_frame(2'd1, 1'b1, 1'b0, 4'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.valid = 1'b1;
      bus.wD    = 1'b0;
      tick();
    end
    bus.valid = 1'b1;
    bus.wD    = 1'b0;
    #2 rstN = 1'b0;
    #1;
    chk("mid_rst_ready", bus.ready, 1);
    chk("mid_rst_rvalid", bus.rValid, 0);
    chk("mid_rst_rd", bus.rD, 0);
    chk("mid_rst_err", bus.err, 0);
    @(negedge clk);
    bus.valid = 1'b0;
    rstN      = 1'b1;
    tick();
    single_read(4'd3, got);
    chk("rst_keep_word", got, 8'hA5);

    send_frame(2'd1, 1'b1, 1'b0, 4'd7);
    tick();
    send_word(8'hC3, 1'b0, -1, 0);
    tick();
    single_read(4'd7, got);
    chk("post_rst_frame", got, 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
